// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: state codes,
// major opcodes and the datapath mux select values.
package riscv_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECR    = 4'd6;
    localparam state_t S_EXECI    = 4'd7;
    localparam state_t S_ALUWB    = 4'd8;
    localparam state_t S_BEQ      = 4'd9;
    localparam state_t S_JAL      = 4'd10;
    localparam state_t S_HALT     = 4'd11;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALUOUT  = 2'b00,
        RES_MEMDATA = 2'b01,
        RES_ALU     = 2'b10
    } result_src_e;

endpackage

// File: rtl/multicycle_control_fsm_counters.sv
// Free-running cycle and retired-instruction counters for the control FSM.
// Both wrap silently; reset clears them.
module ctrl_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             retire,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instret_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (run)
                cycle_q <= cycle_q + CNT_W'(1);
            if (retire)
                instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;

endmodule

// File: rtl/multicycle_control_fsm.sv
// Instruction-level sequencer for the multicycle RV32I core: next-state logic,
// datapath select/strobe decode and the performance counters.
module multicycle_control_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             adr_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       result_src,
    output logic             halted,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    state_t state_q;
    state_t next_state;
    logic   pc_write_raw, ir_write_raw, mem_read_raw, mem_write_raw, reg_write_raw;
    logic   retire;

    always_ff @(posedge clk) begin
        if (!reset)
            state_q <= S_FETCH;
        else
            state_q <= next_state;
    end

    always_comb begin
        next_state = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXECR;
                    OP_I:         next_state = S_EXECI;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_JAL:       next_state = S_JAL;
                    default:      next_state = S_HALT;
                endcase
            end
            S_MEMADR:   next_state = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
            S_MEMWRITE: if (mem_ready) next_state = S_FETCH;
            S_EXECR, S_EXECI, S_JAL:   next_state = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BEQ:   next_state = S_FETCH;
            S_HALT:     next_state = S_HALT;
            default:    next_state = S_FETCH;
        endcase
    end

    // Selects follow the registered state only; pc_write/ir_write carry the
    // mem_ready and zero terms combinationally.
    always_comb begin
        pc_write_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        mem_read_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        adr_src       = 1'b0;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALUOP_ADD;
        result_src    = RES_ALUOUT;
        halted        = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_raw = 1'b1;
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALU;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_read_raw = 1'b1;
                adr_src      = 1'b1;
            end
            S_MEMWB: begin
                result_src    = RES_MEMDATA;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                mem_write_raw = 1'b1;
                adr_src       = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB:  reg_write_raw = 1'b1;
            S_BEQ: begin
                alu_src_a    = SRCA_RS1;
                alu_op       = ALUOP_SUB;
                pc_write_raw = zero;
            end
            S_JAL: begin
                alu_src_a    = SRCA_OLDPC;
                alu_src_b    = SRCB_FOUR;
                pc_write_raw = 1'b1;
            end
            S_HALT:   halted = 1'b1;
            default:  ;
        endcase
    end

    // Strobes are killed while reset is held so a stale state cannot write.
    assign pc_write  = pc_write_raw  & reset;
    assign ir_write  = ir_write_raw  & reset;
    assign mem_read  = mem_read_raw  & reset;
    assign mem_write = mem_write_raw & reset;
    assign reg_write = reg_write_raw & reset;
    assign state_o   = state_q;

    assign retire = reset & ((state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BEQ) ||
                             ((state_q == S_MEMWRITE) && mem_ready));

    ctrl_perf_counters #(.CNT_W(CNT_W)) u_perf (
        .clk         (clk),
        .reset       (reset),
        .run         (state_q != S_HALT),
        .retire      (retire),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Cycle-by-cycle vector bench for the multicycle control FSM with a
// scoreboard of expected observations.
module tb_multicycle_control_fsm;
    import riscv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, halted;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
    logic [3:0]  state_o;
    logic [31:0] cycle_cnt, instret_cnt;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src), .halted(halted),
        .state_o(state_o), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    typedef struct packed {
        logic [3:0]  st;
        logic        pcw, irw, adr, mrd, mwr, rwr;
        logic [1:0]  a, b, op, rs;
        logic        hlt;
        logic [31:0] cyc, ins;
    } obs_t;

    // strb = {pc_write, ir_write, mem_read, mem_write, reg_write}
    typedef struct {
        logic       rst;
        logic [6:0] opc;
        logic       z;
        logic       mr;
        logic [3:0] st;
        logic [4:0] strb;
    } vec_t;

    localparam logic [4:0] NONE = 5'b00000, PCW = 5'b10000, FET = 5'b11100,
                           MRD = 5'b00100, MWR = 5'b00010, RWR = 5'b00001;

    vec_t        vecs[$];
    obs_t        sb[$];
    int          applied = 0;
    int          miscompares = 0;
    logic [31:0] ecyc = 0;
    logic [31:0] eins = 0;

    function automatic obs_t expect_of(vec_t v, logic [31:0] c, logic [31:0] n);
        obs_t e;
        e = '0;
        e.st = v.st;
        {e.pcw, e.irw, e.mrd, e.mwr, e.rwr} = v.strb;
        e.cyc = c;
        e.ins = n;
        case (v.st)
            4'd0:  begin e.b = 2'b10; e.rs = 2'b10; end
            4'd1:  begin e.a = 2'b01; e.b = 2'b01; end
            4'd2:  begin e.a = 2'b10; e.b = 2'b01; end
            4'd3:  e.adr = 1'b1;
            4'd4:  e.rs = 2'b01;
            4'd5:  e.adr = 1'b1;
            4'd6:  begin e.a = 2'b10; e.op = 2'b10; end
            4'd7:  begin e.a = 2'b10; e.b = 2'b01; e.op = 2'b10; end
            4'd9:  begin e.a = 2'b10; e.op = 2'b01; end
            4'd10: begin e.a = 2'b01; e.b = 2'b10; end
            4'd11: e.hlt = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o = {state_o, pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
             alu_src_a, alu_src_b, alu_op, result_src, halted, cycle_cnt, instret_cnt};
        return o;
    endfunction

    task automatic add(input logic r, input logic [6:0] o, input logic z, input logic m,
                       input logic [3:0] s, input logic [4:0] k);
        vec_t v;
        v.rst = r; v.opc = o; v.z = z; v.mr = m; v.st = s; v.strb = k;
        vecs.push_back(v);
    endtask

    task automatic check_obs(input string name);
        obs_t e, a;
        e = sb.pop_front();
        a = sample();
        applied++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, a, e);
        end
    endtask

    task automatic cmp32(input string name, input logic [31:0] a, input logic [31:0] e);
        applied++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, a, e);
        end
    endtask

    // Drive one vector, score it, then advance the bench's counter model.
    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        reset = v.rst; opcode = v.opc; zero = v.z; mem_ready = v.mr;
        sb.push_back(expect_of(v, ecyc, eins));
        #2;
        check_obs(name);
        if (!v.rst) begin
            ecyc = 0;
            eins = 0;
        end else begin
            if (v.st != 4'd11) ecyc = ecyc + 1;
            if (v.st == 4'd4 || v.st == 4'd8 || v.st == 4'd9 || (v.st == 4'd5 && v.mr)) eins = eins + 1;
        end
    endtask

    initial begin
        vec_t v;
        reset = 1'b0; opcode = OP_R; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);

        // reset held, then R-type
        for (int i = 0; i < 3; i++) add(0, OP_R, 0, 1, 0, NONE);
        add(1, OP_R, 0, 1, 0, FET);  add(1, OP_R, 0, 1, 1, NONE);
        add(1, OP_R, 0, 1, 6, NONE); add(1, OP_R, 0, 1, 8, RWR);
        // lw with two MEMREAD waits; mem_ready low in MEMADR must be ignored
        add(1, OP_LW, 0, 1, 0, FET); add(1, OP_LW, 0, 1, 1, NONE);
        add(1, OP_LW, 0, 0, 2, NONE); add(1, OP_LW, 0, 0, 3, MRD);
        add(1, OP_LW, 0, 0, 3, MRD); add(1, OP_LW, 0, 1, 3, MRD);
        add(1, OP_LW, 0, 1, 4, RWR);
        // fetch wait then sw with one write wait
        add(1, OP_SW, 0, 0, 0, MRD); add(1, OP_SW, 0, 1, 0, FET);
        add(1, OP_SW, 0, 1, 1, NONE); add(1, OP_SW, 0, 1, 2, NONE);
        add(1, OP_SW, 0, 0, 5, MWR); add(1, OP_SW, 0, 1, 5, MWR);
        // beq taken, beq not taken
        add(1, OP_BEQ, 1, 1, 0, FET); add(1, OP_BEQ, 1, 1, 1, NONE); add(1, OP_BEQ, 1, 1, 9, PCW);
        add(1, OP_BEQ, 0, 1, 0, FET); add(1, OP_BEQ, 0, 1, 1, NONE); add(1, OP_BEQ, 0, 1, 9, NONE);
        // jal, I-type
        add(1, OP_JAL, 0, 1, 0, FET); add(1, OP_JAL, 0, 1, 1, NONE);
        add(1, OP_JAL, 0, 1, 10, PCW); add(1, OP_JAL, 0, 1, 8, RWR);
        add(1, OP_I, 0, 1, 0, FET); add(1, OP_I, 0, 1, 1, NONE);
        add(1, OP_I, 0, 1, 7, NONE); add(1, OP_I, 0, 1, 8, RWR);
        // reset in the middle of a lw read
        add(1, OP_LW, 0, 1, 0, FET); add(1, OP_LW, 0, 1, 1, NONE);
        add(1, OP_LW, 0, 1, 2, NONE); add(0, OP_LW, 0, 1, 3, NONE);
        add(1, OP_R, 0, 1, 0, FET);  add(1, OP_R, 0, 1, 1, NONE);
        add(1, OP_R, 0, 1, 6, NONE); add(1, OP_R, 0, 1, 8, RWR);
        // illegal opcode
        add(1, 7'h7F, 0, 1, 0, FET); add(1, 7'h7F, 0, 1, 1, NONE);
        add(1, 7'h7F, 0, 1, 11, NONE);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

        // parked in HALT: no strobes, counter frozen, inputs ignored
        for (int i = 0; i < 20; i++) begin
            v.rst = 1; v.opc = 7'($urandom); v.z = 1'($urandom); v.mr = 1'($urandom);
            v.st = 4'd11; v.strb = NONE;
            apply(v, $sformatf("halt%0d", i));
        end

        // reset clears HALT; first cycle after release fetches
        v.rst = 0; v.opc = OP_R; v.z = 0; v.mr = 1; v.st = 4'd11; v.strb = NONE;
        apply(v, "halt_reset");
        v.rst = 1; v.st = 4'd0; v.strb = FET;
        apply(v, "post_halt_fetch");

        // cycle counter wrap
        force dut.u_perf.cycle_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_perf.cycle_q;
        cmp32("wrap_preload", cycle_cnt, 32'hFFFF_FFFF);
        @(negedge clk);
        #2;
        cmp32("wrap_cycle", cycle_cnt, 32'h0000_0000);
        cmp32("wrap_instret", instret_cnt, 32'd0);
        cmp32("wrap_state", {28'd0, state_o}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control sequencer for the multicycle RV32I core that follows the single-cycle `RISC_V_Processor`. It holds the instruction-level state machine and drives the datapath enables and mux selects each cycle. It stalls on a unified memory ready handshake and halts on unsupported opcodes. It also keeps cycle and retired-instruction counters for the bench.

## Interface
Parameters:
- CNT_W, 32, width of cycle/instret counters

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- opcode  in  7  IR[6:0], stable from DECODE until the next FETCH completes
- zero  in  1  ALU zero flag, same cycle
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  PC load enable
- ir_write  out  1  IR/oldPC load enable
- adr_src  out  1  0 = PC, 1 = registered result
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  register file write
- alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1
- alu_src_b  out  2  00 rs2, 01 imm, 10 const 4
- alu_op  out  2  00 add, 01 sub, 10 funct decode
- result_src  out  2  00 ALUOut reg, 01 mem data, 10 ALU result
- halted  out  1  sticky illegal-opcode flag
- state_o  out  4  current state encoding
- cycle_cnt  out  CNT_W  cycles since reset, frozen while halted
- instret_cnt  out  CNT_W  retired instructions

## Operation
- States (state_o encoding): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10, HALT 11.
- Transitions:
  - FETCH→DECODE when mem_ready, else stay in FETCH.
  - DECODE on opcode: 0000011/0100011→MEMADR, 0110011→EXECR, 0010011→EXECI, 1100011→BEQ, 1101111→JAL, any other→HALT.
  - MEMADR→MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD→MEMWB on mem_ready.
  - MEMWRITE→FETCH on mem_ready.
  - EXECR/EXECI→ALUWB. JAL→ALUWB.
  - MEMWB, ALUWB, BEQ→FETCH.
  - HALT→HALT until reset.
- Outputs not listed below are 0.
  - FETCH: mem_read=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10. ir_write and pc_write assert only when mem_ready=1.
  - DECODE: a=01, b=01, alu_op=00 (branch target).
  - MEMADR: a=10, b=01, alu_op=00.
  - MEMREAD: mem_read=1, adr_src=1, result_src=00.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: mem_write=1, adr_src=1, result_src=00.
  - EXECR: a=10, b=00, alu_op=10.
  - EXECI: a=10, b=01, alu_op=10.
  - ALUWB: result_src=00, reg_write=1.
  - BEQ: a=10, b=00, alu_op=01, result_src=00. pc_write=zero (Mealy term).
  - JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1.
  - HALT: all strobes 0, halted=1.
- Counters:
  - cycle_cnt increments every cycle with reset=1 and state≠HALT.
  - instret_cnt increments on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
  - Both wrap modulo 2^CNT_W with no saturation.

## Timing
- Reset values: state FETCH, counters 0, halted 0.
- While reset=0, every strobe (pc_write, ir_write, mem_read, mem_write, reg_write) is forced 0 combinationally, regardless of state register contents.
- Reset mid-instruction: the partial instruction is discarded. First cycle after reset rises is FETCH, and instret is not incremented.
- Cycles per instruction with zero wait:
  - lw 5
  - sw, R, I, jal 4
  - beq 3
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. The request stays asserted and all other outputs stay stable.
- mem_ready is ignored in every other state.
- Illegal opcode reaches HALT 2 cycles after the FETCH handshake. halted rises the cycle after DECODE.
- Select/strobe outputs are decoded from registered state. Only pc_write (BEQ/FETCH terms) and ir_write depend combinationally on inputs.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - state enum (4-bit) and opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - encodings for alu_src_a/b, alu_op, result_src
- Sub-module `ctrl_perf_counters` holds both counters. Inputs: run enable, retire pulse.
- FSM next-state and output decode live in the top module.

## Test plan
- Reset held 0 for 3 cycles, then released with mem_ready=1 → state_o=0 and strobes 0 during reset; ir_write=1 and pc_write=1 in first cycle after release; counters 0→1.
- R-type (opcode 0110011) with mem_ready=1 → states 0,1,6,8,0; reg_write=1 only in ALUWB; instret_cnt=1 after 4 cycles.
- lw with mem_ready held 0 for 2 cycles in MEMREAD → mem_read and adr_src=1 stable for 3 cycles; total 7 cycles; reg_write with result_src=01 once.
- beq twice, first with zero=1 then zero=0 → pc_write pulses in BEQ only in the first case; each takes 3 cycles; instret_cnt=2.
- Opcode 1111111 → HALT reached, halted=1, cycle_cnt frozen at its value; no strobes for 20 cycles; reset clears everything.
- Preload cycle_cnt to 0xFFFFFFFF via force → increments to 0x00000000 with no other effect.
